// File: rtl/i2s_sample_rx_if.sv
// Bundle of I2S serial inputs and decoded stereo sample outputs.
// The source side drives the serial lines; the receiver side produces the samples.
`timescale 1ns / 1ps

interface i2s_sample_rx_if #(
    parameter int unsigned SAMPLE_WIDTH = 16
);
    logic                    bclk;
    logic                    lrclk;
    logic                    sdata;
    logic [SAMPLE_WIDTH-1:0] left_sample;
    logic [SAMPLE_WIDTH-1:0] right_sample;
    logic                    sample_valid;
    logic                    frame_err;

    modport master (
        output bclk,
        output lrclk,
        output sdata,
        input  left_sample,
        input  right_sample,
        input  sample_valid,
        input  frame_err
    );

    modport slave (
        input  bclk,
        input  lrclk,
        input  sdata,
        output left_sample,
        output right_sample,
        output sample_valid,
        output frame_err
    );
endinterface

// File: rtl/i2s_sample_rx.sv
// Slave-side I2S receiver: synchronises bclk/lrclk/sdata into clk, decodes standard
// I2S framing (MSB first, one bclk after each lrclk edge) and emits one stereo pair per frame.
// The interface SAMPLE_WIDTH must match this module's SAMPLE_WIDTH.
`timescale 1ns / 1ps

module i2s_sample_rx #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    i2s_sample_rx_if.slave    bus
);

    localparam int unsigned CntW = $clog2(SAMPLE_WIDTH + 2);
    localparam logic [CntW-1:0] CntFull = CntW'(SAMPLE_WIDTH);
    localparam logic [CntW-1:0] CntSat  = CntW'(SAMPLE_WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StRecv} state_e;

    // Synchroniser chains: index 0 samples the pin, index SYNC_STAGES-1 is the synced value.
    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lrclk_sync_q;
    logic [SYNC_STAGES-1:0] sdata_sync_q;
    logic                   bclk_prev_q;

    logic bclk_s;
    logic lrclk_s;
    logic sdata_s;
    logic br;

    // Decode state
    state_e                  state_q;
    logic [CntW-1:0]         bit_cnt_q;
    logic [SAMPLE_WIDTH-1:0] shift_q;
    logic                    ws_prev_q;
    logic                    ws_seen_q;   // ws_prev_q holds a real sample, not the reset value
    logic [SAMPLE_WIDTH-1:0] left_hold_q;
    logic                    hold_valid_q;

    // One-cycle staging between the decode and the output registers
    logic                    pair_pend_q;
    logic                    err_pend_q;
    logic [SAMPLE_WIDTH-1:0] pend_left_q;
    logic [SAMPLE_WIDTH-1:0] pend_right_q;

    // Output registers
    logic [SAMPLE_WIDTH-1:0] left_sample_q;
    logic [SAMPLE_WIDTH-1:0] right_sample_q;
    logic                    sample_valid_q;
    logic                    frame_err_q;

    logic [CntW-1:0]         cnt_inc;
    logic [SAMPLE_WIDTH-1:0] shift_in;
    logic                    boundary;
    logic                    word_ok;

    assign bclk_s  = bclk_sync_q[SYNC_STAGES-1];
    assign lrclk_s = lrclk_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
    assign br      = bclk_s & ~bclk_prev_q;

    // Bring the asynchronous serial inputs into the clk domain and remember the last bclk.
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            sdata_sync_q <= '0;
            bclk_prev_q  <= 1'b0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bus.bclk};
            lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], bus.lrclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], bus.sdata};
            bclk_prev_q  <= bclk_s;
        end
    end

    // Per-bit bookkeeping: saturating count, MSB-first shift of the first SAMPLE_WIDTH bits.
    always_comb begin
        cnt_inc  = (bit_cnt_q == CntSat) ? bit_cnt_q : bit_cnt_q + 1'b1;
        shift_in = (bit_cnt_q < CntFull) ? {shift_q[SAMPLE_WIDTH-2:0], sdata_s} : shift_q;
        boundary = ws_seen_q && (lrclk_s != ws_prev_q);
        word_ok  = (cnt_inc >= CntFull);
    end

    // Framing FSM: aligns on the first lrclk change, then judges each word at its boundary bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ws_prev_q    <= 1'b0;
            ws_seen_q    <= 1'b0;
            left_hold_q  <= '0;
            hold_valid_q <= 1'b0;
            pair_pend_q  <= 1'b0;
            err_pend_q   <= 1'b0;
            pend_left_q  <= '0;
            pend_right_q <= '0;
        end else begin
            pair_pend_q <= 1'b0;
            err_pend_q  <= 1'b0;
            if (br) begin
                ws_prev_q <= lrclk_s;
                ws_seen_q <= 1'b1;
                unique case (state_q)
                    StIdle: begin
                        if (boundary) begin
                            state_q   <= StRecv;
                            bit_cnt_q <= '0;
                            shift_q   <= '0;
                        end
                    end
                    StRecv: begin
                        if (boundary) begin
                            // The boundary bit is the LSB slot of channel ws_prev_q.
                            if (!word_ok) begin
                                err_pend_q   <= 1'b1;
                                hold_valid_q <= 1'b0;
                            end else if (!ws_prev_q) begin
                                left_hold_q  <= shift_in;
                                hold_valid_q <= 1'b1;
                            end else if (hold_valid_q) begin
                                pair_pend_q  <= 1'b1;
                                pend_left_q  <= left_hold_q;
                                pend_right_q <= shift_in;
                                hold_valid_q <= 1'b0;
                            end
                            bit_cnt_q <= '0;
                            shift_q   <= '0;
                        end else begin
                            bit_cnt_q <= cnt_inc;
                            shift_q   <= shift_in;
                        end
                    end
                endcase
            end
        end
    end

    // Registered outputs: both samples update together with the valid strobe and then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_sample_q  <= '0;
            right_sample_q <= '0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            sample_valid_q <= pair_pend_q;
            frame_err_q    <= err_pend_q;
            if (pair_pend_q) begin
                left_sample_q  <= pend_left_q;
                right_sample_q <= pend_right_q;
            end
        end
    end

    assign bus.left_sample  = left_sample_q;
    assign bus.right_sample = right_sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.frame_err    = frame_err_q;

endmodule
